// File: rtl/pipe_adder.sv
// pipe_adder: two-stage pipelined adder with valid/ready handshakes on both
// sides and an optional accumulate mode.
// Stage S1 holds the low-half sum, the low-half carry and the two high
// operand halves. Stage S2 is the output register. It adds the high halves
// and the low carry.
// The accumulator is updated when an accumulate result is loaded into S2.
// A new accumulate beat is held off while an earlier accumulate beat is
// still in S1 or S2. This guarantees that every accumulate beat reads an
// up-to-date accumulator.
module pipe_adder #(
    parameter int WIDTH  = 8,
    parameter bit ACC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int H = WIDTH / 2;

    // S1 state
    logic             s1_valid_reg;
    logic             s1_acc_reg;
    logic             s1_lc_reg;
    logic [H-1:0]     s1_lo_reg;
    logic [H-1:0]     s1_xhi_reg;
    logic [H-1:0]     s1_yhi_reg;

    // S2 (output register) state
    logic             out_valid_reg;
    logic             s2_acc_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] acc_reg;

    // Handshake and datapath nets
    logic             eff_mode;
    logic             s2_load;
    logic             s1_free;
    logic             hazard;
    logic             in_fire;
    logic [WIDTH-1:0] acc_rd;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic             c_in;
    logic [H:0]       lo_full;
    logic [H:0]       hi_full;
    logic [WIDTH-1:0] new_sum;
    logic             new_ovf;

    // Handshake logic, operand selection and both half-adders.
    always_comb begin
        eff_mode = ACC_EN & mode;
        s2_load  = s1_valid_reg && (!out_valid_reg || out_ready);
        s1_free  = !s1_valid_reg || s2_load;
        hazard   = eff_mode && ((s1_valid_reg && s1_acc_reg) ||
                                (out_valid_reg && s2_acc_reg));
        in_ready = rst_n && s1_free && !hazard;
        in_fire  = in_valid && in_ready;

        // A beat that is accepted in the same cycle as a clear sees the
        // cleared accumulator.
        acc_rd   = acc_clr ? '0 : acc_reg;
        op_x     = eff_mode ? acc_rd : a;
        op_y     = eff_mode ? a : b;
        c_in     = eff_mode ? 1'b0 : cin;
        lo_full  = {1'b0, op_x[H-1:0]} + {1'b0, op_y[H-1:0]} + {{H{1'b0}}, c_in};

        hi_full  = {1'b0, s1_xhi_reg} + {1'b0, s1_yhi_reg} + {{H{1'b0}}, s1_lc_reg};
        new_sum  = {hi_full[H-1:0], s1_lo_reg};
        new_ovf  = (s1_xhi_reg[H-1] == s1_yhi_reg[H-1]) &&
                   (hi_full[H-1] != s1_xhi_reg[H-1]);
    end

    // S1 register: refill whenever it is empty or its beat moves to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_acc_reg   <= 1'b0;
            s1_lc_reg    <= 1'b0;
            s1_lo_reg    <= '0;
            s1_xhi_reg   <= '0;
            s1_yhi_reg   <= '0;
        end else if (s1_free) begin
            s1_valid_reg <= in_fire;
            if (in_fire) begin
                s1_acc_reg <= eff_mode;
                s1_lc_reg  <= lo_full[H];
                s1_lo_reg  <= lo_full[H-1:0];
                s1_xhi_reg <= op_x[WIDTH-1:H];
                s1_yhi_reg <= op_y[WIDTH-1:H];
            end
        end
    end

    // S2 output register: load from S1 or drain. Hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            s2_acc_reg    <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (s2_load) begin
            out_valid_reg <= 1'b1;
            s2_acc_reg    <= s1_acc_reg;
            sum_reg       <= new_sum;
            cout_reg      <= hi_full[H];
            ovf_reg       <= new_ovf;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    generate
        if (ACC_EN) begin : g_acc
            // Accumulator: a clear takes priority over an accumulate result
            // loaded into S2 in the same cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg <= '0;
                end else if (acc_clr) begin
                    acc_reg <= '0;
                end else if (s2_load && s1_acc_reg) begin
                    acc_reg <= new_sum;
                end
            end
        end else begin : g_no_acc
            assign acc_reg = '0;
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed vectors for pipe_adder (WIDTH=8, ACC_EN=1).
// The expected values are computed by hand. Each result is recorded as
// {ovf, cout, sum}.
module tb_pipe_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       mode;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    int         checks = 0;
    int         errors = 0;
    bit         fired;
    logic [9:0] obs[$];

    pipe_adder #(.WIDTH(8), .ACC_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // This task starts just after a rising edge, with the inputs already
    // driven. It lets the combinational logic settle and records which
    // handshakes complete at the next edge. It then advances to just after
    // that edge.
    task automatic cycle();
        #1;
        fired = in_valid && in_ready;
        if (out_valid && out_ready) obs.push_back({ovf, cout, sum});
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [9:0] exp);
        logic [9:0] v;
        if (obs.size() == 0) begin
            chk({tag, "_missing"}, 32'd0, 32'd1);
        end else begin
            v = obs.pop_front();
            chk(tag, {22'd0, v}, {22'd0, exp});
        end
    endtask

    // Sends one beat with out_ready=1, then checks the exact two-cycle
    // latency and the result.
    task automatic send(input string tag, input logic m, input logic [7:0] av,
                        input logic [7:0] bv, input logic c, input logic clr,
                        input logic [9:0] exp);
        mode = m; a = av; b = bv; cin = c; acc_clr = clr; in_valid = 1'b1;
        cycle();
        chk({tag, "_accept"}, {31'd0, fired}, 32'd1);
        in_valid = 1'b0; acc_clr = 1'b0;
        chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        cycle();
        chk({tag, "_lat2"}, {31'd0, out_valid}, 32'd1);
        cycle();
        expect_out(tag, exp);
    endtask

    initial begin : main
        logic [9:0] tp_exp [4];
        int         n;
        bit         prev;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rel_out_valid", {31'd0, out_valid}, 32'd0);

        // Add-mode vectors
        send("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h00});
        send("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
        send("add_0f_cin", 1'b0, 8'h0F, 8'h00, 1'b1, 1'b0, {1'b0, 1'b0, 8'h10});
        send("add_80_80", 1'b0, 8'h80, 8'h80, 1'b0, 1'b0, {1'b1, 1'b1, 8'h00});
        send("add_a5_5a", 1'b0, 8'hA5, 8'h5A, 1'b1, 1'b0, {1'b0, 1'b1, 8'h00});

        // Full throughput: four add beats on consecutive cycles
        tp_exp[0] = {2'b00, 8'd30}; tp_exp[1] = {2'b00, 8'd33};
        tp_exp[2] = {2'b00, 8'd34}; tp_exp[3] = {2'b00, 8'd37};
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 8'(10 + i); b = 8'(20 + i); cin = 1'(i % 2); in_valid = 1'b1;
            cycle();
            chk($sformatf("tp_accept%0d", i), {31'd0, fired}, 32'd1);
        end
        in_valid = 1'b0; cin = 1'b0;
        repeat (3) cycle();
        for (int i = 0; i < 4; i++) expect_out($sformatf("tp_out%0d", i), tp_exp[i]);

        // Backpressure: 1+1, 2+2, 3+3 with out_ready held low
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 8'(i + 1); b = 8'(i + 1); in_valid = 1'b1;
            cycle();
            chk($sformatf("bp_accept%0d", i), {31'd0, fired}, 32'd1);
        end
        a = 8'd3; b = 8'd3;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("bp_blocked%0d", i), {31'd0, fired}, 32'd0);
            chk($sformatf("bp_hold%0d", i), {22'd0, out_valid, cout, sum}, {22'd0, 1'b1, 1'b0, 8'd2});
        end
        out_ready = 1'b1;
        n = 0;
        while (!fired && n < 5) begin
            cycle();
            n++;
        end
        chk("bp_third_accept", {31'd0, fired}, 32'd1);
        in_valid = 1'b0;
        repeat (4) cycle();
        expect_out("bp_out0", {2'b00, 8'd2});
        expect_out("bp_out1", {2'b00, 8'd4});
        expect_out("bp_out2", {2'b00, 8'd6});
        chk("bp_no_extra", obs.size(), 32'd0);

        // Accumulate a=5 offered continuously: gaps enforced, sums 5, 10, 15
        mode = 1'b1; a = 8'd5; b = 8'hAA; cin = 1'b1; in_valid = 1'b1;
        n = 0; prev = 1'b0;
        for (int i = 0; i < 15 && n < 3; i++) begin
            cycle();
            if (prev) chk($sformatf("acc_gap%0d", i), {31'd0, fired}, 32'd0);
            prev = fired;
            if (fired) n++;
        end
        chk("acc_beats", n, 32'd3);
        in_valid = 1'b0; b = 8'd0; cin = 1'b0;
        repeat (4) cycle();
        expect_out("acc_5", {2'b00, 8'd5});
        expect_out("acc_10", {2'b00, 8'd10});
        expect_out("acc_15", {2'b00, 8'd15});
        chk("acc_no_extra", obs.size(), 32'd0);

        // Clear, then accumulate
        acc_clr = 1'b1;
        cycle();
        acc_clr = 1'b0;
        send("clr_acc_3", 1'b1, 8'd3, 8'd0, 1'b0, 1'b0, {2'b00, 8'd3});
        send("add_keeps_acc", 1'b0, 8'd1, 8'd1, 1'b0, 1'b0, {2'b00, 8'd2});
        send("acc_plus1", 1'b1, 8'd1, 8'd0, 1'b0, 1'b0, {2'b00, 8'd4});
        send("acc_wrap", 1'b1, 8'hFE, 8'd0, 1'b0, 1'b0, {1'b0, 1'b1, 8'h02});
        send("clr_same_cycle", 1'b1, 8'd3, 8'd0, 1'b0, 1'b1, {2'b00, 8'd3});

        // A clear in the commit cycle wins, but the in-flight op still uses acc=3
        mode = 1'b1; a = 8'd2; in_valid = 1'b1;
        cycle();
        chk("clr_commit_accept", {31'd0, fired}, 32'd1);
        in_valid = 1'b0; acc_clr = 1'b1;
        cycle();
        acc_clr = 1'b0;
        cycle();
        expect_out("clr_commit_result", {2'b00, 8'd5});
        send("after_clr_commit", 1'b1, 8'd1, 8'd0, 1'b0, 1'b0, {2'b00, 8'd1});

        // Reset with two beats in flight
        out_ready = 1'b0; mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 8'h40; b = 8'(i); in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sum", {24'd0, sum}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rel_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) cycle();
        chk("mid_rel_no_stale", obs.size(), 32'd0);
        send("rst_acc_zero", 1'b1, 8'd7, 8'd0, 1'b0, 1'b0, {2'b00, 8'd7});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits; SHALL be even and >= 2.
REQ-002 Parameter: ACC_EN, 1, 1 enables accumulate mode; 0 treats mode as 0.
REQ-003 Port: clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: in_valid  input  1  operand beat offered.
REQ-006 Port: in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-007 Port: a  input  WIDTH  operand A (unsigned / two's complement).
REQ-008 Port: b  input  WIDTH  operand B; ignored in accumulate mode.
REQ-009 Port: cin  input  1  carry-in; ignored in accumulate mode.
REQ-010 Port: mode  input  1  0 = add, 1 = accumulate.
REQ-011 Port: acc_clr  input  1  synchronous accumulator clear.
REQ-012 Port: out_valid  output  1  result beat present.
REQ-013 Port: out_ready  input  1  result consumed when out_valid && out_ready.
REQ-014 Port: sum  output  WIDTH  result.
REQ-015 Port: cout  output  1  carry out of bit WIDTH-1.
REQ-016 Port: ovf  output  1  signed overflow of this result.

Function
REQ-017 Add mode SHALL produce {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-018 Accumulate mode SHALL produce {cout,sum} = acc + a; acc SHALL take sum when that result enters the output register.
REQ-019 ovf SHALL be 1 iff the operand MSBs are equal and sum MSB differs from them (operands: a,b in add mode; acc,a in accumulate mode).
REQ-020 Two pipeline stages: S1 registers the low WIDTH/2 sum, low carry and the high operand halves; S2 (output register) adds the high halves plus the low carry.
REQ-021 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held 1.
REQ-022 Throughput SHALL be one beat per cycle for add-mode traffic with out_ready = 1.
REQ-023 A stage SHALL advance when its downstream register is empty or is being drained in the same cycle.
REQ-024 in_ready SHALL be 1 iff S1 is empty or S1 advances this cycle, and not blocked per REQ-025.
REQ-025 When mode = 1, in_ready SHALL be 0 while any accumulate op occupies S1 or S2 (accumulate hazard); in_ready may depend on mode and in_valid, and in_valid SHALL NOT depend on in_ready.
REQ-026 With out_valid = 1 and out_ready = 0, sum, cout and ovf SHALL hold stable and no beat SHALL be lost or duplicated.
REQ-027 acc_clr SHALL zero acc at the clock edge; if an accumulate result commits in the same cycle, the clear SHALL win and acc = 0.
REQ-028 Accumulate ops in flight when acc_clr asserts SHALL complete using the acc value read at S1 entry.
REQ-029 When ACC_EN = 0, mode SHALL be ignored and acc SHALL stay at 0.

Reset
REQ-030 While rst_n = 0: in_ready = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0, acc = 0, both stages empty.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight beats; the first cycle after release SHALL show in_ready = 1 and out_valid = 0.

Verification
REQ-032 WIDTH=8, add, out_ready=1: a=0xFF, b=0x01, cin=0 -> 2 cycles later sum=0x00, cout=1, ovf=0.
REQ-033 Add: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1; a=0x0F, b=0x00, cin=1 -> sum=0x10 (low-to-high carry across the stage split).
REQ-034 Back-to-back add beats 1+1, 2+2, 3+3, then out_ready=0 for 3 cycles -> outputs 2, 4, 6 in order, none lost, in_ready drops once both stages are full.
REQ-035 Accumulate a=5, 5, 5 offered continuously -> in_ready gaps enforced, sums 5, 10, 15; then acc_clr with a=3 accumulate -> sum=3.
REQ-036 rst_n pulsed low with two beats in flight -> outputs zero immediately, no stale out_valid after release, acc = 0.
